// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the fir_ctrl coefficient/sample controller.
package fir_pkg;
   localparam int NTAP_C = 11;
   localparam int NB_C   = 11;
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWAP} fir_ctrl_state_t;
   typedef logic [NB_C-1:0] coef_bank_t [NTAP_C];
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow + live coefficient banks; swap copies shadow to live in one edge.
module fir_coef_bank #(
   parameter int NTAP = 11,
   parameter int NB   = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_we,
   input  logic [3:0]         i_addr,
   input  logic [NB-1:0]      i_data,
   input  logic               i_swap,
   output logic [NTAP*NB-1:0] o_coef
);
   logic [NB-1:0] r_shadow [NTAP];
   logic [NB-1:0] r_active [NTAP];
   // A write in the swap cycle lands in shadow only; live takes the pre-write shadow.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_shadow <= '{default: '0};
         r_active <= '{default: '0};
      end else begin
         if (i_we && i_addr < 4'(NTAP)) r_shadow[i_addr] <= i_data;
         if (i_swap) r_active <= r_shadow;
      end
   for (genvar k = 0; k < NTAP; k++) begin : g_pack
      assign o_coef[k*NB +: NB] = r_active[k];
   end
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: forwards samples to the FIR and commits coefficient updates only
// once every in-flight sample has come out, so each output uses one coefficient set.
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int NTAP = NTAP_C,
   parameter int NB   = NB_C,
   parameter int CW   = 5
) (
   input  logic               clk,
   input  logic               RST,
   input  logic [NB-1:0]      DIN_i,
   input  logic               VIN_i,
   output logic               RDY_o,
   output logic [NB-1:0]      DIN_o,
   output logic               VIN_o,
   input  logic               VOUT_f,
   input  logic               CW_EN,
   input  logic [3:0]         CW_ADDR,
   input  logic [NB-1:0]      CW_DATA,
   input  logic               COMMIT,
   output logic [NTAP*NB-1:0] COEF_o,
   output logic               BUSY_o,
   output logic               ERR_o
);
   fir_ctrl_state_t r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [NB-1:0] r_din;
   logic          r_vin, r_err, w_acc, w_err_set;
   assign RDY_o  = r_state == S_RUN;
   assign BUSY_o = r_state != S_RUN;
   assign DIN_o  = r_din;
   assign VIN_o  = r_vin;
   assign ERR_o  = r_err;
   assign w_acc  = VIN_i & RDY_o;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN:   w_next = COMMIT ? S_DRAIN : S_RUN;
         S_DRAIN: w_next = r_cnt == '0 ? S_SWAP : S_DRAIN;
         default: w_next = S_RUN;
      endcase
   end
   // Simultaneous acceptance and completion cancel out, so neither error case applies.
   always_comb begin
      w_cnt_nx  = r_cnt;
      w_err_set = CW_EN & (CW_ADDR >= 4'(NTAP));
      if (w_acc && !VOUT_f) begin
         if (r_cnt == '1) w_err_set = 1'b1;
         else w_cnt_nx = r_cnt + 1'b1;
      end else if (!w_acc && VOUT_f) begin
         if (r_cnt == '0) w_err_set = 1'b1;
         else w_cnt_nx = r_cnt - 1'b1;
      end
   end
   always_ff @(posedge clk or posedge RST)
      if (RST) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
         r_din   <= '0;
         r_vin   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nx;
         r_vin   <= w_acc;
         r_err   <= r_err | w_err_set;
         if (w_acc) r_din <= DIN_i;
      end
   fir_coef_bank #(.NTAP(NTAP), .NB(NB)) u_bank (
      .clk    (clk),
      .rst    (RST),
      .i_we   (CW_EN),
      .i_addr (CW_ADDR),
      .i_data (CW_DATA),
      .i_swap (r_state == S_SWAP),
      .o_coef (COEF_o)
   );
endmodule
